// File: rtl/demux5_1to2_buf_pkg.sv
// Shared constants for the 5-bit 1:2 buffered demux: default widths and the
// select encoding that picks output A or B.
package demux5_1to2_buf_pkg;

    localparam int DATA_W_DEF = 5;
    localparam int DEPTH_DEF  = 2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux5_1to2_buf_if.sv
// Stream bundle for the demux: one valid/ready input with a select bit and
// two independent buffered valid/ready outputs with occupancy counts.
interface demux5_1to2_buf_if #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] outa_data;
    logic              outa_valid;
    logic              outa_ready;
    logic [CNT_W-1:0]  outa_count;

    logic [DATA_W-1:0] outb_data;
    logic              outb_valid;
    logic              outb_ready;
    logic [CNT_W-1:0]  outb_count;

    // Producer and both consumers, seen from outside the demux.
    modport master (
        output in_data, in_sel, in_valid, outa_ready, outb_ready,
        input  in_ready, outa_data, outa_valid, outa_count,
               outb_data, outb_valid, outb_count
    );

    modport slave (
        input  in_data, in_sel, in_valid, outa_ready, outb_ready,
        output in_ready, outa_data, outa_valid, outa_count,
               outb_data, outb_valid, outb_count
    );

endinterface

// File: rtl/demux5_fifo.sv
// Small synchronous FIFO used for each demux output. Storage has no reset;
// pointers, count and the last-read value are async-reset.
module demux5_fifo #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Pop requests while empty and pushes while full are dropped here.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                last_d   = mem_q[rd_ptr_q];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    // Empty FIFO shows the last word read out, so the output never exposes an unwritten slot.
    assign head_o = empty_o ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/demux5_1to2_buf.sv
// 1:2 demux with a FIFO per output: each input word is steered by its select
// bit, and a stalled consumer only backpressures words headed its way.
module demux5_1to2_buf
    import demux5_1to2_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic flush_i,
    demux5_1to2_buf_if.slave bus
);

    logic full_a, empty_a;
    logic full_b, empty_b;
    logic push_a, push_b;
    logic in_ready;

    // Ready follows the select combinationally; a full FIFO refuses even if it pops this cycle.
    assign in_ready = !flush_i && !((bus.in_sel == SEL_B) ? full_b : full_a);
    assign push_a   = bus.in_valid && in_ready && (bus.in_sel == SEL_A);
    assign push_b   = bus.in_valid && in_ready && (bus.in_sel == SEL_B);

    assign bus.in_ready   = in_ready;
    assign bus.outa_valid = !empty_a;
    assign bus.outb_valid = !empty_b;

    demux5_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (push_a),
        .data_i  (bus.in_data),
        .pop_i   (bus.outa_ready),
        .full_o  (full_a),
        .empty_o (empty_a),
        .count_o (bus.outa_count),
        .head_o  (bus.outa_data)
    );

    demux5_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (push_b),
        .data_i  (bus.in_data),
        .pop_i   (bus.outb_ready),
        .full_o  (full_b),
        .empty_o (empty_b),
        .count_o (bus.outb_count),
        .head_o  (bus.outb_data)
    );

endmodule

// File: tb/tb_demux5_1to2_buf.sv
// Directed bench for the buffered 1:2 demux: routing, backpressure, full
// refusal, pointer wrap against a queue model, flush and async reset.
module tb_demux5_1to2_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

    demux5_1to2_buf_if #(.DATA_W(5), .DEPTH(2)) bus ();

    demux5_1to2_buf #(.DATA_W(5), .DEPTH(2)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [4:0] d);
        bus.in_sel   = sel;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.in_data = 5'h0; bus.in_sel = 1'b0; bus.in_valid = 1'b0;
        bus.outa_ready = 1'b0; bus.outb_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.outa_valid !== 1'b0 || bus.outb_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got a=%b b=%b want 0 0", bus.outa_valid, bus.outb_valid); end
        total++; if (bus.outa_count !== 2'd0 || bus.outb_count !== 2'd0) begin
            bad++; $display("FAIL reset_count: got a=%0d b=%0d want 0 0", bus.outa_count, bus.outb_count); end
        total++; if (bus.outa_data !== 5'h0 || bus.outb_data !== 5'h0) begin
            bad++; $display("FAIL reset_data: got a=%h b=%h want 0 0", bus.outa_data, bus.outb_data); end
        rst_n = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_a: got %b want 1", bus.in_ready); end
        bus.in_sel = 1'b1; #1;
        total++; if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_b: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_routing();
        bus.outa_ready = 1'b1; bus.outb_ready = 1'b1;
        push(1'b0, 5'h0A);
        total++; if (bus.outa_valid !== 1'b1 || bus.outa_data !== 5'h0A) begin
            bad++; $display("FAIL route_a: got v=%b d=%h want 1 0a", bus.outa_valid, bus.outa_data); end
        total++; if (bus.outb_valid !== 1'b0) begin
            bad++; $display("FAIL route_a_cross: outb_valid got %b want 0", bus.outb_valid); end
        tick();
        total++; if (bus.outa_valid !== 1'b0) begin
            bad++; $display("FAIL route_a_once: outa_valid got %b want 0", bus.outa_valid); end
        push(1'b1, 5'h15);
        total++; if (bus.outb_valid !== 1'b1 || bus.outb_data !== 5'h15) begin
            bad++; $display("FAIL route_b: got v=%b d=%h want 1 15", bus.outb_valid, bus.outb_data); end
        total++; if (bus.outa_valid !== 1'b0) begin
            bad++; $display("FAIL route_b_cross: outa_valid got %b want 0", bus.outa_valid); end
        tick();
        total++; if (bus.outb_valid !== 1'b0) begin
            bad++; $display("FAIL route_b_once: outb_valid got %b want 0", bus.outb_valid); end
    endtask

    task automatic test_backpressure();
        bus.outa_ready = 1'b0; bus.outb_ready = 1'b0;
        push(1'b0, 5'h01);
        push(1'b0, 5'h02);
        bus.in_sel = 1'b0; #1;
        total++; if (bus.outa_count !== 2'd2) begin
            bad++; $display("FAIL bp_count_a: got %0d want 2", bus.outa_count); end
        total++; if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_ready_sel0: got %b want 0", bus.in_ready); end
        bus.in_sel = 1'b1; #1;
        total++; if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_ready_sel1: got %b want 1", bus.in_ready); end
        push(1'b1, 5'h1F);
        total++; if (bus.outb_valid !== 1'b1 || bus.outb_data !== 5'h1F || bus.outb_count !== 2'd1) begin
            bad++; $display("FAIL bp_b: got v=%b d=%h c=%0d want 1 1f 1", bus.outb_valid, bus.outb_data, bus.outb_count); end
        bus.outb_ready = 1'b1;
        bus.outa_ready = 1'b1; #1;
        total++; if (bus.outa_data !== 5'h01) begin
            bad++; $display("FAIL bp_pop1: got %h want 01", bus.outa_data); end
        tick();
        total++; if (bus.outa_data !== 5'h02 || bus.outa_valid !== 1'b1) begin
            bad++; $display("FAIL bp_pop2: got v=%b d=%h want 1 02", bus.outa_valid, bus.outa_data); end
        tick();
        total++; if (bus.outa_valid !== 1'b0 || bus.outb_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drained: got a=%b b=%b want 0 0", bus.outa_valid, bus.outb_valid); end
        total++; if (bus.outa_data !== 5'h02) begin
            bad++; $display("FAIL bp_hold_last: got %h want 02", bus.outa_data); end
    endtask

    task automatic test_full_pop();
        bus.outa_ready = 1'b0; bus.outb_ready = 1'b0;
        push(1'b0, 5'h01);
        push(1'b0, 5'h02);
        bus.in_sel = 1'b0; bus.in_data = 5'h03; bus.in_valid = 1'b1;
        bus.outa_ready = 1'b1; #1;
        total++; if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL full_refuse: in_ready got %b want 0", bus.in_ready); end
        total++; if (bus.outa_data !== 5'h01) begin
            bad++; $display("FAIL full_head1: got %h want 01", bus.outa_data); end
        tick();
        total++; if (bus.outa_count !== 2'd1 || bus.outa_data !== 5'h02) begin
            bad++; $display("FAIL full_after_pop: got c=%0d d=%h want 1 02", bus.outa_count, bus.outa_data); end
        total++; if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL full_ready_next: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.outa_count !== 2'd1 || bus.outa_data !== 5'h03) begin
            bad++; $display("FAIL full_push_pop: got c=%0d d=%h want 1 03", bus.outa_count, bus.outa_data); end
        tick();
        total++; if (bus.outa_count !== 2'd0 || bus.outa_valid !== 1'b0) begin
            bad++; $display("FAIL full_drain: got c=%0d v=%b want 0 0", bus.outa_count, bus.outa_valid); end
    endtask

    task automatic test_wrap();
        logic [4:0] words [10];
        logic [4:0] q [$];
        int idx = 0;
        int cyc = 0;
        bit push_now, pop_now;
        for (int i = 0; i < 10; i++) words[i] = 5'($urandom_range(0, 31));
        bus.in_sel = 1'b0; bus.outb_ready = 1'b0;
        while ((idx < 10 || q.size() > 0) && cyc < 200) begin
            bus.in_valid   = (idx < 10);
            bus.in_data    = (idx < 10) ? words[idx] : 5'h0;
            bus.outa_ready = 1'($urandom_range(0, 1));
            #1;
            total++; if (bus.in_ready !== (q.size() < 2)) begin
                bad++; $display("FAIL wrap_ready: cyc %0d got %b want %b", cyc, bus.in_ready, q.size() < 2); end
            total++; if (int'(bus.outa_count) !== q.size() || bus.outa_count > 2'd2) begin
                bad++; $display("FAIL wrap_count: cyc %0d got %0d want %0d", cyc, bus.outa_count, q.size()); end
            total++; if (bus.outa_valid !== (q.size() > 0)) begin
                bad++; $display("FAIL wrap_valid: cyc %0d got %b want %b", cyc, bus.outa_valid, q.size() > 0); end
            if (q.size() > 0) begin
                total++; if (bus.outa_data !== q[0]) begin
                    bad++; $display("FAIL wrap_data: cyc %0d got %h want %h", cyc, bus.outa_data, q[0]); end
            end
            push_now = (idx < 10) && (q.size() < 2);
            pop_now  = bus.outa_ready && (q.size() > 0);
            if (pop_now) void'(q.pop_front());
            if (push_now) begin q.push_back(words[idx]); idx++; end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0; bus.outa_ready = 1'b0;
        total++; if (cyc >= 200) begin
            bad++; $display("FAIL wrap_timeout: got %0d cycles want <200", cyc); end
    endtask

    task automatic test_flush_reset();
        bus.outa_ready = 1'b0; bus.outb_ready = 1'b0;
        push(1'b0, 5'h04); push(1'b0, 5'h05); push(1'b1, 5'h06);
        total++; if (bus.outa_count !== 2'd2 || bus.outb_count !== 2'd1) begin
            bad++; $display("FAIL fl_fill: got a=%0d b=%0d want 2 1", bus.outa_count, bus.outb_count); end
        flush = 1'b1; bus.in_sel = 1'b1; bus.in_data = 5'h07; bus.in_valid = 1'b1;
        bus.outa_ready = 1'b1; #1;
        total++; if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL fl_ready: got %b want 0", bus.in_ready); end
        tick();
        flush = 1'b0; bus.in_valid = 1'b0; bus.outa_ready = 1'b0; #1;
        total++; if (bus.outa_count !== 2'd0 || bus.outb_count !== 2'd0 ||
                     bus.outa_valid !== 1'b0 || bus.outb_valid !== 1'b0) begin
            bad++; $display("FAIL fl_clear: got ca=%0d cb=%0d va=%b vb=%b want 0 0 0 0",
                            bus.outa_count, bus.outb_count, bus.outa_valid, bus.outb_valid); end
        push(1'b0, 5'h08); push(1'b0, 5'h09); push(1'b1, 5'h0B);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.outa_count !== 2'd0 || bus.outb_count !== 2'd0 ||
                     bus.outa_valid !== 1'b0 || bus.outb_valid !== 1'b0) begin
            bad++; $display("FAIL rst_async: got ca=%0d cb=%0d va=%b vb=%b want 0 0 0 0",
                            bus.outa_count, bus.outb_count, bus.outa_valid, bus.outb_valid); end
        total++; if (bus.outa_data !== 5'h0 || bus.outb_data !== 5'h0) begin
            bad++; $display("FAIL rst_async_data: got a=%h b=%h want 0 0", bus.outa_data, bus.outb_data); end
        rst_n = 1'b1;
        tick();
        bus.in_sel = 1'b0; #1;
        total++; if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_full_pop();
        test_wrap();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
